// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

  localparam int DEF_INDEX_BITS      = 4;
  localparam int DEF_LINE_WORDS_BITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_FILL   = 2'd2
  } state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one write port driven by the refill engine,
// two combinational read ports for the low and high word of a fetch.
module icache_array #(
  parameter int INDEX_BITS      = 4,
  parameter int LINE_WORDS_BITS = 2,
  parameter int TAG_BITS        = 24
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_word_we,
  input  logic                       i_set_valid,
  input  logic [INDEX_BITS-1:0]      i_w_idx,
  input  logic [LINE_WORDS_BITS-1:0] i_w_word,
  input  logic [31:0]                i_w_data,
  input  logic [TAG_BITS-1:0]        i_w_tag,
  input  logic [INDEX_BITS-1:0]      i_lo_idx,
  input  logic [LINE_WORDS_BITS-1:0] i_lo_word,
  output logic                       o_lo_valid,
  output logic [TAG_BITS-1:0]        o_lo_tag,
  output logic [31:0]                o_lo_data,
  input  logic [INDEX_BITS-1:0]      i_hi_idx,
  input  logic [LINE_WORDS_BITS-1:0] i_hi_word,
  output logic                       o_hi_valid,
  output logic [TAG_BITS-1:0]        o_hi_tag,
  output logic [31:0]                o_hi_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << (INDEX_BITS + LINE_WORDS_BITS);

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [WORDS];

  // Only the valid bits need reset; tag and data are qualified by them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_clear) begin
      r_valid[i_w_idx] <= 1'b0;
    end else if (i_set_valid) begin
      r_valid[i_w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_word_we) begin
      r_data[{i_w_idx, i_w_word}] <= i_w_data;
    end
    if (i_set_valid) begin
      r_tag[i_w_idx] <= i_w_tag;
    end
  end

  assign o_lo_valid = r_valid[i_lo_idx];
  assign o_lo_tag   = r_tag[i_lo_idx];
  assign o_lo_data  = r_data[{i_lo_idx, i_lo_word}];
  assign o_hi_valid = r_valid[i_hi_idx];
  assign o_hi_tag   = r_tag[i_hi_idx];
  assign o_hi_data  = r_data[{i_hi_idx, i_hi_word}];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: lookup/refill FSM plus halfword alignment
// that stitches a 32-bit fetch across word and line boundaries.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS      = DEF_INDEX_BITS,
  parameter int LINE_WORDS_BITS = DEF_LINE_WORDS_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        to_icache,
  input  logic [31:0] pc_to_icache,
  output logic        have_result,
  output logic [31:0] inst_from_icache,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  localparam int OFF_BITS  = LINE_WORDS_BITS + 2;
  localparam int LINE_BITS = 32 - OFF_BITS;
  localparam int TAG_BITS  = LINE_BITS - INDEX_BITS;

  state_e                     r_state, w_state_nxt;
  logic [31:1]                r_req_pc, w_req_pc_nxt;
  logic [LINE_BITS-1:0]       r_fill_line, w_fill_line_nxt;
  logic [LINE_WORDS_BITS-1:0] r_cnt, w_cnt_nxt;
  logic                       r_have_result, w_have_result_nxt;
  logic [31:0]                r_inst, w_inst_nxt;
  logic                       w_clear, w_word_we, w_set_valid;

  logic [LINE_BITS-1:0]       w_lo_line, w_hi_line;
  logic [LINE_WORDS_BITS-1:0] w_lo_word, w_hi_word;
  logic                       w_lo_valid, w_hi_valid;
  logic [TAG_BITS-1:0]        w_lo_tag, w_hi_tag;
  logic [31:0]                w_lo_data, w_hi_data;
  logic                       w_lo_hit, w_hi_hit, w_need_hi;
  logic                       w_unused_pc_bit0;

  // The high word is the next word; it moves to the next line (and may carry
  // into the tag) when the low word is the last one in its line.
  assign w_lo_line        = r_req_pc[31:OFF_BITS];
  assign w_lo_word        = r_req_pc[OFF_BITS-1:2];
  assign w_hi_word        = w_lo_word + LINE_WORDS_BITS'(1);
  assign w_hi_line        = (w_lo_word == '1) ? w_lo_line + LINE_BITS'(1) : w_lo_line;
  assign w_need_hi        = r_req_pc[1];
  assign w_unused_pc_bit0 = pc_to_icache[0];

  assign w_lo_hit = w_lo_valid && (w_lo_tag == w_lo_line[LINE_BITS-1:INDEX_BITS]);
  assign w_hi_hit = w_hi_valid && (w_hi_tag == w_hi_line[LINE_BITS-1:INDEX_BITS]);

  icache_array #(
    .INDEX_BITS     (INDEX_BITS),
    .LINE_WORDS_BITS(LINE_WORDS_BITS),
    .TAG_BITS       (TAG_BITS)
  ) u_array (
    .i_clk      (clk_in),
    .i_rst      (rst_in),
    .i_clear    (w_clear),
    .i_word_we  (w_word_we),
    .i_set_valid(w_set_valid),
    .i_w_idx    (w_fill_line_nxt[INDEX_BITS-1:0]),
    .i_w_word   (r_cnt),
    .i_w_data   (mem_data),
    .i_w_tag    (r_fill_line[LINE_BITS-1:INDEX_BITS]),
    .i_lo_idx   (w_lo_line[INDEX_BITS-1:0]),
    .i_lo_word  (w_lo_word),
    .o_lo_valid (w_lo_valid),
    .o_lo_tag   (w_lo_tag),
    .o_lo_data  (w_lo_data),
    .i_hi_idx   (w_hi_line[INDEX_BITS-1:0]),
    .i_hi_word  (w_hi_word),
    .o_hi_valid (w_hi_valid),
    .o_hi_tag   (w_hi_tag),
    .o_hi_data  (w_hi_data)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state       <= ST_IDLE;
      r_req_pc      <= '0;
      r_fill_line   <= '0;
      r_cnt         <= '0;
      r_have_result <= 1'b0;
      r_inst        <= '0;
    end else if (rdy_in) begin
      r_state       <= w_state_nxt;
      r_req_pc      <= w_req_pc_nxt;
      r_fill_line   <= w_fill_line_nxt;
      r_cnt         <= w_cnt_nxt;
      r_have_result <= w_have_result_nxt;
      r_inst        <= w_inst_nxt;
    end
  end

  // A line is invalidated as its fill starts, so an abandoned fill never hits.
  always_comb begin
    w_state_nxt       = r_state;
    w_req_pc_nxt      = r_req_pc;
    w_fill_line_nxt   = r_fill_line;
    w_cnt_nxt         = r_cnt;
    w_have_result_nxt = 1'b0;
    w_inst_nxt        = r_inst;
    w_clear           = 1'b0;
    w_word_we         = 1'b0;
    w_set_valid       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (to_icache) begin
          w_req_pc_nxt = pc_to_icache[31:1];
          w_state_nxt  = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (!w_lo_hit) begin
          w_fill_line_nxt = w_lo_line;
          w_cnt_nxt       = '0;
          w_clear         = 1'b1;
          w_state_nxt     = ST_FILL;
        end else if (w_need_hi && !w_hi_hit) begin
          w_fill_line_nxt = w_hi_line;
          w_cnt_nxt       = '0;
          w_clear         = 1'b1;
          w_state_nxt     = ST_FILL;
        end else begin
          w_have_result_nxt = 1'b1;
          w_inst_nxt        = w_need_hi ? {w_hi_data[15:0], w_lo_data[31:16]} : w_lo_data;
          w_state_nxt       = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (mem_ready) begin
          w_word_we = 1'b1;
          w_cnt_nxt = r_cnt + LINE_WORDS_BITS'(1);
          if (r_cnt == '1) begin
            w_set_valid = 1'b1;
            w_state_nxt = ST_LOOKUP;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!rdy_in) begin
      w_clear     = 1'b0;
      w_word_we   = 1'b0;
      w_set_valid = 1'b0;
    end
  end

  assign have_result      = r_have_result;
  assign inst_from_icache = r_inst;
  assign mem_req          = (r_state == ST_FILL);
  assign mem_addr         = {r_fill_line, r_cnt, 2'b00};

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: byte-addressed memory model, line-level
// cache model, randomized memory latency and randomized fetch addresses.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        to_icache = 1'b0;
  logic [31:0] pc_to_icache = '0;
  logic        have_result;
  logic [31:0] inst_from_icache;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data = '0;

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] memOverride [logic [31:0]];
  logic [31:0] seenAddrs [$];
  logic [31:0] expAddrs  [$];
  bit          modelValid [16];
  logic [23:0] modelTag   [16];
  int          respDelay = 0;

  icache dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .to_icache       (to_icache),
    .pc_to_icache    (pc_to_icache),
    .have_result     (have_result),
    .inst_from_icache(inst_from_icache),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ready       (mem_ready),
    .mem_data        (mem_data)
  );

  always #5 clk_in = ~clk_in;

  // Backing memory: explicit words where the scenario needs them, otherwise a
  // bijective hash of the word address so every word is distinct.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] aligned;
    aligned = {a[31:2], 2'b00};
    if (memOverride.exists(aligned)) return memOverride[aligned];
    return (aligned * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory controller: one-cycle mem_ready pulses after a random 0-2 cycle gap.
  initial begin
    forever begin
      @(posedge clk_in or posedge rst_in);
      #2;
      if (rst_in) begin
        mem_ready = 1'b0;
        respDelay = 0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (mem_req) begin
        if (respDelay > 0) begin
          respDelay--;
        end else begin
          mem_data  = memWord(mem_addr);
          mem_ready = 1'b1;
          respDelay = $urandom_range(0, 2);
        end
      end
    end
  end

  always @(posedge clk_in) begin
    if (!rst_in && rdy_in && mem_req && mem_ready) seenAddrs.push_back(mem_addr);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic modelReset();
    for (int i = 0; i < 16; i++) modelValid[i] = 1'b0;
  endtask

  // Line-level model: which lines a fetch touches, which of them miss (lo line
  // first), and the four little-endian bytes starting at the halfword PC.
  task automatic modelAccess(input logic [31:0] pc, output logic [31:0] expInst);
    logic [31:0] pcA, hiPc, a, w;
    logic [27:0] lines [2];
    logic [3:0]  idx;
    int          nLines;
    pcA      = pc & 32'hFFFF_FFFE;
    hiPc     = pcA + 32'd4;
    lines[0] = pcA[31:4];
    lines[1] = hiPc[31:4];
    nLines   = pcA[1] ? 2 : 1;
    expAddrs.delete();
    for (int i = 0; i < nLines; i++) begin
      idx = lines[i][3:0];
      if (!(modelValid[idx] && modelTag[idx] == lines[i][27:4])) begin
        for (int k = 0; k < 4; k++) expAddrs.push_back({lines[i], 4'b0000} + 32'(4 * k));
        modelValid[idx] = 1'b1;
        modelTag[idx]   = lines[i][27:4];
      end
    end
    for (int j = 0; j < 4; j++) begin
      a = pcA + 32'(j);
      w = memWord(a);
      expInst[8*j +: 8] = w[8*a[1:0] +: 8];
    end
  endtask

  task automatic runRequest(input logic [31:0] pc, output logic [31:0] inst,
                            output int latency, output bit gotIt, output bit extraPulse);
    seenAddrs.delete();
    @(negedge clk_in);
    to_icache    = 1'b1;
    pc_to_icache = pc;
    @(posedge clk_in);
    @(negedge clk_in);
    to_icache    = 1'b0;
    pc_to_icache = $urandom;
    latency = 1;
    gotIt   = 1'b0;
    while (!gotIt && latency < 2000) begin
      if (have_result === 1'b1) gotIt = 1'b1;
      else begin
        @(negedge clk_in);
        latency++;
      end
    end
    inst = inst_from_icache;
    @(negedge clk_in);
    extraPulse = (have_result !== 1'b0);
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    modelReset();
    repeat (3) @(negedge clk_in);
    nChecks++; if (have_result !== 1'b0) begin nFails++; $display("[TB] FAIL reset_have_result: got %b expected 0", have_result); end
    nChecks++; if (inst_from_icache !== 32'h0) begin nFails++; $display("[TB] FAIL reset_inst: got %h expected 00000000", inst_from_icache); end
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
    nChecks++; if (mem_addr !== 32'h0) begin nFails++; $display("[TB] FAIL reset_mem_addr: got %h expected 00000000", mem_addr); end
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_cold_miss();
    logic [31:0] inst, expInst;
    int lat; bit got, extra;
    memOverride[32'h10] = 32'h1111_1111;
    memOverride[32'h14] = 32'h2222_2222;
    memOverride[32'h18] = 32'h3333_3333;
    memOverride[32'h1C] = 32'h4444_4444;
    modelAccess(32'h10, expInst);
    runRequest(32'h10, inst, lat, got, extra);
    nChecks++; if (!got) begin nFails++; $display("[TB] FAIL cold_response: got none expected one have_result"); end
    nChecks++; if (seenAddrs.size() != 4) begin nFails++; $display("[TB] FAIL cold_handshakes: got %0d expected 4", seenAddrs.size()); end
    for (int i = 0; i < 4 && i < seenAddrs.size(); i++) begin
      nChecks++; if (seenAddrs[i] !== 32'h10 + 32'(4 * i)) begin nFails++; $display("[TB] FAIL cold_addr%0d: got %h expected %h", i, seenAddrs[i], 32'h10 + 32'(4 * i)); end
    end
    nChecks++; if (inst !== 32'h1111_1111) begin nFails++; $display("[TB] FAIL cold_inst: got %h expected 11111111", inst); end
    nChecks++; if (extra) begin nFails++; $display("[TB] FAIL cold_pulse_width: got pulse longer than 1 cycle expected 1"); end
  endtask

  task automatic test_warm_hit();
    logic [31:0] inst, expInst;
    int lat; bit got, extra;
    modelAccess(32'h18, expInst);
    runRequest(32'h18, inst, lat, got, extra);
    nChecks++; if (seenAddrs.size() != 0) begin nFails++; $display("[TB] FAIL warm_traffic: got %0d handshakes expected 0", seenAddrs.size()); end
    nChecks++; if (!got || lat != 2) begin nFails++; $display("[TB] FAIL warm_latency: got %0d (resp=%0d) expected 2", lat, got); end
    nChecks++; if (inst !== 32'h3333_3333) begin nFails++; $display("[TB] FAIL warm_inst: got %h expected 33333333", inst); end
    repeat (3) @(negedge clk_in);
    nChecks++; if (inst_from_icache !== 32'h3333_3333) begin nFails++; $display("[TB] FAIL warm_hold: got %h expected 33333333", inst_from_icache); end
  endtask

  task automatic test_half_offset();
    logic [31:0] inst, expInst;
    int lat; bit got, extra;
    modelAccess(32'h12, expInst);
    runRequest(32'h12, inst, lat, got, extra);
    nChecks++; if (seenAddrs.size() != 0) begin nFails++; $display("[TB] FAIL half_traffic: got %0d handshakes expected 0", seenAddrs.size()); end
    nChecks++; if (!got || inst !== 32'h2222_1111) begin nFails++; $display("[TB] FAIL half_inst: got %h (resp=%0d) expected 22221111", inst, got); end
  endtask

  task automatic test_straddle();
    logic [31:0] inst, expInst;
    int lat; bit got, extra;
    memOverride[32'h20] = 32'hAAAA_5555;
    modelAccess(32'h1E, expInst);
    runRequest(32'h1E, inst, lat, got, extra);
    nChecks++; if (seenAddrs.size() != 4) begin nFails++; $display("[TB] FAIL straddle_handshakes: got %0d expected 4", seenAddrs.size()); end
    for (int i = 0; i < 4 && i < seenAddrs.size(); i++) begin
      nChecks++; if (seenAddrs[i] !== 32'h20 + 32'(4 * i)) begin nFails++; $display("[TB] FAIL straddle_addr%0d: got %h expected %h", i, seenAddrs[i], 32'h20 + 32'(4 * i)); end
    end
    nChecks++; if (!got || inst !== 32'h5555_4444) begin nFails++; $display("[TB] FAIL straddle_inst: got %h (resp=%0d) expected 55554444", inst, got); end
  endtask

  task automatic test_conflict();
    logic [31:0] inst, expInst;
    int lat; bit got, extra;
    modelAccess(32'h110, expInst);
    runRequest(32'h110, inst, lat, got, extra);
    nChecks++; if (seenAddrs.size() != 4 || seenAddrs[0] !== 32'h110) begin nFails++; $display("[TB] FAIL conflict_refill: got %0d handshakes expected 4 from 00000110", seenAddrs.size()); end
    nChecks++; if (!got || inst !== expInst) begin nFails++; $display("[TB] FAIL conflict_inst: got %h expected %h", inst, expInst); end
    modelAccess(32'h10, expInst);
    runRequest(32'h10, inst, lat, got, extra);
    nChecks++; if (seenAddrs.size() != 4) begin nFails++; $display("[TB] FAIL conflict_remiss: got %0d handshakes expected 4", seenAddrs.size()); end
    nChecks++; if (!got || inst !== 32'h1111_1111) begin nFails++; $display("[TB] FAIL conflict_reinst: got %h expected 11111111", inst); end
  endtask

  task automatic test_wrap();
    logic [31:0] inst, expInst;
    int lat; bit got, extra;
    modelAccess(32'hFFFF_FFFE, expInst);
    runRequest(32'hFFFF_FFFE, inst, lat, got, extra);
    nChecks++; if (seenAddrs.size() != expAddrs.size()) begin nFails++; $display("[TB] FAIL wrap_handshakes: got %0d expected %0d", seenAddrs.size(), expAddrs.size()); end
    for (int i = 0; i < expAddrs.size() && i < seenAddrs.size(); i++) begin
      nChecks++; if (seenAddrs[i] !== expAddrs[i]) begin nFails++; $display("[TB] FAIL wrap_addr%0d: got %h expected %h", i, seenAddrs[i], expAddrs[i]); end
    end
    nChecks++; if (!got || inst !== expInst) begin nFails++; $display("[TB] FAIL wrap_inst: got %h expected %h", inst, expInst); end
  endtask

  task automatic test_stall();
    logic [31:0] inst, expInst, stallAddr;
    int lat; bit got, extra;
    modelAccess(32'h0000_0344, expInst);
    seenAddrs.delete();
    fork
      runRequest(32'h0000_0344, inst, lat, got, extra);
      begin
        int waitCycles = 0;
        int nBefore;
        while (seenAddrs.size() < 1 && waitCycles < 500) begin
          @(negedge clk_in);
          waitCycles++;
        end
        nChecks++; if (seenAddrs.size() < 1) begin nFails++; $display("[TB] FAIL stall_first_word: got 0 handshakes expected 1"); end
        rdy_in    = 1'b0;
        stallAddr = mem_addr;
        nBefore   = seenAddrs.size();
        repeat (5) begin
          @(negedge clk_in);
          nChecks++; if (mem_addr !== stallAddr || mem_req !== 1'b1) begin nFails++; $display("[TB] FAIL stall_hold: got addr %h req %b expected addr %h req 1", mem_addr, mem_req, stallAddr); end
        end
        nChecks++; if (seenAddrs.size() != nBefore) begin nFails++; $display("[TB] FAIL stall_consumed: got %0d handshakes expected %0d", seenAddrs.size(), nBefore); end
        rdy_in = 1'b1;
      end
    join
    nChecks++; if (seenAddrs.size() != 4) begin nFails++; $display("[TB] FAIL stall_handshakes: got %0d expected 4", seenAddrs.size()); end
    for (int i = 0; i < expAddrs.size() && i < seenAddrs.size(); i++) begin
      nChecks++; if (seenAddrs[i] !== expAddrs[i]) begin nFails++; $display("[TB] FAIL stall_addr%0d: got %h expected %h", i, seenAddrs[i], expAddrs[i]); end
    end
    nChecks++; if (!got || inst !== expInst) begin nFails++; $display("[TB] FAIL stall_inst: got %h expected %h", inst, expInst); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] inst, expInst;
    int lat, waitCycles; bit got, extra, sawPulse;
    seenAddrs.delete();
    @(negedge clk_in);
    to_icache    = 1'b1;
    pc_to_icache = 32'h0000_0588;
    @(posedge clk_in);
    @(negedge clk_in);
    to_icache  = 1'b0;
    waitCycles = 0;
    while (seenAddrs.size() < 1 && waitCycles < 500) begin
      @(negedge clk_in);
      waitCycles++;
    end
    nChecks++; if (seenAddrs.size() != 1) begin nFails++; $display("[TB] FAIL rstfill_first_word: got %0d handshakes expected 1", seenAddrs.size()); end
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL rstfill_mem_req: got %b expected 0", mem_req); end
    modelReset();
    sawPulse = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (10) begin
      @(negedge clk_in);
      if (have_result !== 1'b0) sawPulse = 1'b1;
    end
    nChecks++; if (sawPulse) begin nFails++; $display("[TB] FAIL rstfill_no_result: got have_result pulse expected none"); end
    modelAccess(32'h0000_0588, expInst);
    runRequest(32'h0000_0588, inst, lat, got, extra);
    nChecks++; if (seenAddrs.size() != 4) begin nFails++; $display("[TB] FAIL rstfill_remiss: got %0d handshakes expected 4", seenAddrs.size()); end
    nChecks++; if (!got || inst !== expInst) begin nFails++; $display("[TB] FAIL rstfill_inst: got %h expected %h", inst, expInst); end
  endtask

  task automatic test_random();
    logic [31:0] inst, expInst, pc;
    int lat; bit got, extra;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FF00 | (32'($urandom_range(0, 127)) << 1);
      else pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 127)) << 1);
      modelAccess(pc, expInst);
      runRequest(pc, inst, lat, got, extra);
      nChecks++; if (!got || inst !== expInst) begin nFails++; $display("[TB] FAIL rand_inst pc=%h: got %h expected %h", pc, inst, expInst); end
      nChecks++; if (seenAddrs.size() != expAddrs.size()) begin nFails++; $display("[TB] FAIL rand_handshakes pc=%h: got %0d expected %0d", pc, seenAddrs.size(), expAddrs.size()); end
      else begin
        for (int i = 0; i < expAddrs.size(); i++) begin
          nChecks++; if (seenAddrs[i] !== expAddrs[i]) begin nFails++; $display("[TB] FAIL rand_addr pc=%h #%0d: got %h expected %h", pc, i, seenAddrs[i], expAddrs[i]); end
        end
      end
      nChecks++; if (extra) begin nFails++; $display("[TB] FAIL rand_pulse_width pc=%h: got >1 cycle expected 1", pc); end
      if (expAddrs.size() == 0) begin
        nChecks++; if (lat != 2) begin nFails++; $display("[TB] FAIL rand_hit_latency pc=%h: got %0d expected 2", pc, lat); end
      end
    end
  endtask

  initial begin
    $display("[TB] icache bench start");
    test_reset();
    test_cold_miss();
    test_warm_hit();
    test_half_offset();
    test_straddle();
    test_conflict();
    test_wrap();
    test_stall();
    test_reset_mid_fill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
